// File: rtl/md4_pkg.sv
`default_nettype none
// md4_pkg: MD4 round constants, shift/word-order tables, encodings and step primitives
// shared by the round engine and its step datapath.
package md4_pkg;

   typedef enum logic [1:0] {
      MODE_R1   = 2'd0,
      MODE_R2   = 2'd1,
      MODE_R3   = 2'd2,
      MODE_FULL = 2'd3
   } mode_t;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      DONE = 2'd2
   } eng_state_t;

   typedef struct packed {
      logic [31:0] a;
      logic [31:0] b;
      logic [31:0] c;
      logic [31:0] d;
   } md4_state_t;

   localparam logic [31:0] K_TAB [3] = '{32'h0000_0000, 32'h5A82_7999, 32'h6ED9_EBA1};

   localparam logic [4:0] SHIFT_TAB [3][4] = '{
      '{5'd3, 5'd7, 5'd11, 5'd19},
      '{5'd3, 5'd5, 5'd9,  5'd13},
      '{5'd3, 5'd9, 5'd11, 5'd15}
   };

   localparam logic [3:0] WORD_TAB [3][16] = '{
      '{4'd0, 4'd1, 4'd2,  4'd3,  4'd4, 4'd5, 4'd6,  4'd7,  4'd8, 4'd9, 4'd10, 4'd11, 4'd12, 4'd13, 4'd14, 4'd15},
      '{4'd0, 4'd4, 4'd8,  4'd12, 4'd1, 4'd5, 4'd9,  4'd13, 4'd2, 4'd6, 4'd10, 4'd14, 4'd3,  4'd7,  4'd11, 4'd15},
      '{4'd0, 4'd8, 4'd4,  4'd12, 4'd2, 4'd10, 4'd6, 4'd14, 4'd1, 4'd9, 4'd5,  4'd13, 4'd3,  4'd11, 4'd7,  4'd15}
   };

   function automatic logic [31:0] k_of(input logic [1:0] r);
      case (r)
         2'd0:    return K_TAB[0];
         2'd1:    return K_TAB[1];
         default: return K_TAB[2];
      endcase
   endfunction

   function automatic logic [4:0] shift_of(input logic [1:0] r, input logic [1:0] p);
      case (r)
         2'd0:    return SHIFT_TAB[0][p];
         2'd1:    return SHIFT_TAB[1][p];
         default: return SHIFT_TAB[2][p];
      endcase
   endfunction

   function automatic logic [3:0] word_of(input logic [1:0] r, input logic [3:0] i);
      case (r)
         2'd0:    return WORD_TAB[0][i];
         2'd1:    return WORD_TAB[1][i];
         default: return WORD_TAB[2][i];
      endcase
   endfunction

   function automatic logic [31:0] f_r(input logic [1:0] r, input logic [31:0] b,
                                       input logic [31:0] c, input logic [31:0] d);
      case (r)
         2'd0:    return (b & c) | (~b & d);
         2'd1:    return (b & c) | (b & d) | (c & d);
         default: return b ^ c ^ d;
      endcase
   endfunction

   function automatic logic [31:0] rotl(input logic [31:0] v, input logic [4:0] s);
      logic [63:0] dbl;
      dbl = {v, v} << s;
      return dbl[63:32];
   endfunction

endpackage
`default_nettype wire

// File: rtl/md4_step.sv
`default_nettype none
// md4_step: one combinational MD4 step. The updated word always sits in slot a, and the
// state is rotated (a,b,c,d) -> (d,new,b,c) so the next step again updates slot a.
module md4_step
   import md4_pkg::*;
(
   input  md4_state_t  st_in,
   input  logic [31:0] word,
   input  logic [1:0]  round,
   input  logic [1:0]  pos,
   output md4_state_t  st_out
);

   logic [31:0] sum;

   assign sum    = st_in.a + f_r(round, st_in.b, st_in.c, st_in.d) + word + k_of(round);
   assign st_out = {st_in.d, rotl(sum, shift_of(round, pos)), st_in.b, st_in.c};

endmodule
`default_nettype wire

// File: rtl/md4_round_engine.sv
`default_nettype none
// md4_round_engine: iterative MD4 compression core running UNROLL chained steps per clock,
// executing one selected round or the full three-round compression with feed-forward.
module md4_round_engine
   import md4_pkg::*;
#(
   parameter int UNROLL = 1,
   parameter int W      = 32
) (
   input  logic          clk,
   input  logic          rst_n,
   input  logic          in_valid,
   output logic          in_ready,
   input  logic [1:0]    mode,
   input  logic [W-1:0]  a_in,
   input  logic [W-1:0]  b_in,
   input  logic [W-1:0]  c_in,
   input  logic [W-1:0]  d_in,
   input  logic [16*W-1:0] x,
   output logic          out_valid,
   input  logic          out_ready,
   output logic [W-1:0]  a_out,
   output logic [W-1:0]  b_out,
   output logic [W-1:0]  c_out,
   output logic [W-1:0]  d_out
);

   generate
      if (W != 32) begin : g_bad_width
         $error("md4_round_engine: W must be 32");
      end
      if (!(UNROLL == 1 || UNROLL == 2 || UNROLL == 4 || UNROLL == 8 || UNROLL == 16)) begin : g_bad_unroll
         $error("md4_round_engine: UNROLL must be 1, 2, 4, 8 or 16");
      end
   endgenerate

   localparam logic [5:0] STEP_INC = 6'(UNROLL);

   eng_state_t  state;
   mode_t       cur_mode;
   logic [5:0]  cnt;
   logic [5:0]  n_steps;
   md4_state_t  ws;
   md4_state_t  iv;
   logic [511:0] xr;
   md4_state_t  chain [UNROLL+1];

   assign n_steps  = (cur_mode == MODE_FULL) ? 6'd48 : 6'd16;
   assign chain[0] = ws;

   generate
      for (genvar u = 0; u < UNROLL; u++) begin : g_step
         logic [5:0]  t;
         logic [1:0]  rnd;
         logic [31:0] word;

         assign t    = cnt + 6'(u);
         // Full compression walks rounds 0..2 from the step index; single-round modes pin it.
         assign rnd  = (cur_mode == MODE_FULL) ? t[5:4] : cur_mode;
         assign word = xr[{word_of(rnd, t[3:0]), 5'd0} +: 32];

         md4_step u_step (
            .st_in  (chain[u]),
            .word   (word),
            .round  (rnd),
            .pos    (t[1:0]),
            .st_out (chain[u+1])
         );
      end
   endgenerate

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state     <= IDLE;
         cur_mode  <= MODE_R1;
         cnt       <= '0;
         ws        <= '0;
         iv        <= '0;
         xr        <= '0;
         in_ready  <= 1'b1;
         out_valid <= 1'b0;
         a_out     <= '0;
         b_out     <= '0;
         c_out     <= '0;
         d_out     <= '0;
      end else begin
         case (state)
            IDLE: begin
               if (in_valid && in_ready) begin
                  ws       <= {a_in, b_in, c_in, d_in};
                  xr       <= x;
                  cur_mode <= mode_t'(mode);
                  if (mode_t'(mode) == MODE_FULL) begin
                     iv <= {a_in, b_in, c_in, d_in};
                  end
                  cnt      <= '0;
                  in_ready <= 1'b0;
                  state    <= RUN;
               end
            end
            RUN: begin
               ws  <= chain[UNROLL];
               cnt <= cnt + STEP_INC;
               if (cnt + STEP_INC == n_steps) begin
                  state <= DONE;
               end
            end
            DONE: begin
               // First DONE cycle registers the result; then hold it until accepted.
               if (!out_valid) begin
                  out_valid <= 1'b1;
                  if (cur_mode == MODE_FULL) begin
                     a_out <= ws.a + iv.a;
                     b_out <= ws.b + iv.b;
                     c_out <= ws.c + iv.c;
                     d_out <= ws.d + iv.d;
                  end else begin
                     a_out <= ws.a;
                     b_out <= ws.b;
                     c_out <= ws.c;
                     d_out <= ws.d;
                  end
               end else if (out_ready) begin
                  out_valid <= 1'b0;
                  in_ready  <= 1'b1;
                  state     <= IDLE;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule
`default_nettype wire

// File: tb/tb_md4_round_engine.sv
`default_nettype none
// tb_md4_round_engine: directed vectors checked against a plain-arithmetic MD4 model
// and hand-computed digests.
module tb_md4_round_engine;

   localparam int UNROLL = 4;
   localparam int SH [3][4] = '{'{3, 7, 11, 19}, '{3, 5, 9, 13}, '{3, 9, 11, 15}};
   localparam logic [127:0] IV        = {32'h67452301, 32'hefcdab89, 32'h98badcfe, 32'h10325476};
   localparam logic [127:0] DIG_EMPTY = {32'he0cfd631, 32'h31e96ad1, 32'hd7593cb7, 32'hc089c0e0};
   localparam logic [127:0] DIG_ABC   = {32'h7a0148a4, 32'h52d821af, 32'he80ac15f, 32'h9d72a67a};

   logic         clk = 1'b0;
   logic         rst_n = 1'b0;
   logic         in_valid = 1'b0;
   logic         out_ready = 1'b0;
   logic [1:0]   mode = 2'd0;
   logic [31:0]  a_in = '0, b_in = '0, c_in = '0, d_in = '0;
   logic [511:0] x = '0;
   logic         in_ready, out_valid;
   logic [31:0]  a_out, b_out, c_out, d_out;

   int           n_vec = 0;
   int           n_fail = 0;
   logic [127:0] exp_out = '0;
   logic [127:0] hold_val = '0;
   logic         exp_valid = 1'b0;

   md4_round_engine #(.UNROLL(UNROLL), .W(32)) dut (
      .clk(clk), .rst_n(rst_n),
      .in_valid(in_valid), .in_ready(in_ready), .mode(mode),
      .a_in(a_in), .b_in(b_in), .c_in(c_in), .d_in(d_in), .x(x),
      .out_valid(out_valid), .out_ready(out_ready),
      .a_out(a_out), .b_out(b_out), .c_out(c_out), .d_out(d_out)
   );

   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [127:0] act, input logic [127:0] req);
      n_vec++;
      if (act !== req) begin
         n_fail++;
         $display("FAIL %s: got %h, required %h", name, act, req);
      end
   endtask

   // Textbook MD4: four named registers, target chosen by step position.
   function automatic logic [127:0] md4_model(input logic [1:0] m, input logic [127:0] start,
                                              input logic [511:0] blk);
      logic [31:0] v [4];
      logic [31:0] fb, fc, fd, fv, kk, w, t;
      int first, last, tgt, wi, s;
      v[0] = start[127:96]; v[1] = start[95:64]; v[2] = start[63:32]; v[3] = start[31:0];
      first = (m == 2'd3) ? 0 : int'(m);
      last  = (m == 2'd3) ? 2 : int'(m);
      for (int r = first; r <= last; r++) begin
         for (int i = 0; i < 16; i++) begin
            tgt = (4 - (i % 4)) % 4;
            fb = v[(tgt + 1) % 4]; fc = v[(tgt + 2) % 4]; fd = v[(tgt + 3) % 4];
            if (r == 0) begin
               fv = (fb & fc) | (~fb & fd); kk = 32'h0; wi = i;
            end else if (r == 1) begin
               fv = (fb & fc) | (fb & fd) | (fc & fd); kk = 32'h5A827999; wi = (i % 4) * 4 + i / 4;
            end else begin
               fv = fb ^ fc ^ fd; kk = 32'h6ED9EBA1;
               wi = ((i & 1) << 3) | ((i & 2) << 1) | ((i & 4) >> 1) | ((i & 8) >> 3);
            end
            w = blk[wi*32 +: 32];
            s = SH[r][i % 4];
            t = v[tgt] + fv + w + kk;
            v[tgt] = (t << s) | (t >> (32 - s));
         end
      end
      if (m == 2'd3) begin
         v[0] += start[127:96]; v[1] += start[95:64]; v[2] += start[63:32]; v[3] += start[31:0];
      end
      return {v[0], v[1], v[2], v[3]};
   endfunction

   function automatic logic [127:0] add_words(input logic [127:0] p, input logic [127:0] q);
      return {p[127:96] + q[127:96], p[95:64] + q[95:64], p[63:32] + q[63:32], p[31:0] + q[31:0]};
   endfunction

   // Every cycle out of reset: a valid result must match the model, otherwise outputs hold.
   always @(negedge clk) begin
      if (rst_n) begin
         if (out_valid) begin
            if (exp_valid) chk("result", {a_out, b_out, c_out, d_out}, exp_out);
            else           chk("spurious_out_valid", {127'b0, out_valid}, 128'd0);
            chk("in_ready_in_done", {127'b0, in_ready}, 128'd0);
         end else begin
            chk("idle_hold", {a_out, b_out, c_out, d_out}, hold_val);
         end
      end
   end

   task automatic do_req(input logic [1:0] m, input logic [127:0] start, input logic [511:0] blk,
                         input int stall, output logic [127:0] got, output logic [127:0] mdl);
      int n;
      int lat;
      lat = ((m == 2'd3) ? 48 : 16) / UNROLL + 1;
      @(negedge clk);
      chk("in_ready_before_req", {127'b0, in_ready}, 128'd1);
      mode = m; {a_in, b_in, c_in, d_in} = start; x = blk;
      in_valid  = 1'b1;
      out_ready = (stall == 0);
      exp_out   = md4_model(m, start, blk);
      exp_valid = 1'b1;
      @(posedge clk); #1;
      in_valid = 1'b0;
      n = 0;
      while (!out_valid && n < 200) begin
         @(posedge clk); #1;
         n++;
      end
      chk("latency", 128'(n), 128'(lat));
      got = {a_out, b_out, c_out, d_out};
      for (int s = 0; s < stall; s++) begin
         if (s == 3) begin
            in_valid = 1'b1; mode = ~m; x = ~blk; a_in = ~a_in;
         end
         if (s == 4) in_valid = 1'b0;
         @(posedge clk); #1;
         chk("stall_in_ready", {127'b0, in_ready}, 128'd0);
         chk("stall_out_valid", {127'b0, out_valid}, 128'd1);
      end
      in_valid  = 1'b0;
      out_ready = 1'b1;
      @(posedge clk); #1;
      out_ready = 1'b0;
      hold_val  = exp_out;
      exp_valid = 1'b0;
      chk("post_hs_out_valid", {127'b0, out_valid}, 128'd0);
      chk("post_hs_in_ready", {127'b0, in_ready}, 128'd1);
      mdl = exp_out;
   endtask

   logic [511:0] blk_empty, blk_abc;
   logic [127:0] g0, g1, g2, m0, m1, m2;

   initial begin
      blk_empty = '0; blk_empty[31:0] = 32'h00000080;
      blk_abc   = '0; blk_abc[31:0] = 32'h80636261; blk_abc[14*32 +: 32] = 32'h18;

      chk("model_empty", md4_model(2'd3, IV, blk_empty), DIG_EMPTY);
      chk("model_abc", md4_model(2'd3, IV, blk_abc), DIG_ABC);

      repeat (3) @(posedge clk);
      #1;
      chk("reset_out_valid", {127'b0, out_valid}, 128'd0);
      chk("reset_outputs", {a_out, b_out, c_out, d_out}, 128'd0);
      @(negedge clk); rst_n = 1'b1;
      @(posedge clk); #1;
      chk("reset_in_ready", {127'b0, in_ready}, 128'd1);

      do_req(2'd3, IV, blk_empty, 0, g0, m0);
      chk("digest_empty", g0, DIG_EMPTY);
      do_req(2'd3, IV, blk_abc, 10, g0, m0);
      chk("digest_abc_stalled", g0, DIG_ABC);

      do_req(2'd0, IV, blk_abc, 0, g0, m0);
      do_req(2'd1, m0, blk_abc, 2, g1, m1);
      do_req(2'd2, m1, blk_abc, 0, g2, m2);
      chk("chain_feed_forward", add_words(g2, IV), DIG_ABC);

      do_req(2'd0, 128'd0, 512'd0, 1, g0, m0);
      chk("zero_round1", g0, 128'd0);

      // Abort a full compression at step 20.
      @(negedge clk);
      mode = 2'd3; {a_in, b_in, c_in, d_in} = IV; x = blk_abc; in_valid = 1'b1;
      @(posedge clk); #1;
      in_valid = 1'b0;
      repeat (20 / UNROLL) @(posedge clk);
      #2 rst_n = 1'b0;
      #1;
      hold_val = '0;
      chk("abort_out_valid", {127'b0, out_valid}, 128'd0);
      chk("abort_outputs", {a_out, b_out, c_out, d_out}, 128'd0);
      @(negedge clk); rst_n = 1'b1;
      @(posedge clk); #1;
      chk("abort_in_ready", {127'b0, in_ready}, 128'd1);
      do_req(2'd3, IV, blk_abc, 0, g0, m0);
      chk("digest_abc_after_abort", g0, DIG_ABC);

      repeat (3) @(posedge clk);
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
      $finish;
   end

endmodule
`default_nettype wire
